// File: rtl/wch_scheduler_pkg.sv
// Shared constants, state encoding and rate helper
// for the weight-change update scheduler.
package wch_scheduler_pkg;

    localparam int M_DEF           = 784;
    localparam int N_DEF           = 8;
    localparam int W               = 24;
    localparam int TIMEOUT_DEF     = 16;
    localparam int DECAY_SHIFT_DEF = 6;
    localparam int IPW             = 10;
    // Shortest WAIT dwell; keeps start-to-start at M+6 or more.
    localparam int MIN_WAIT        = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SWEEP,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    // lr - (lr >> sh), never below 1.
    function automatic logic [W-1:0] decay_floor(
        input logic [W-1:0] lr,
        input int unsigned  sh
    );
        logic [W-1:0] v;
        v = lr - (lr >> sh);
        return (v == '0) ? W'(1) : v;
    endfunction

endpackage

// File: rtl/wch_scheduler_if.sv
// Request / datapath bundle of the update scheduler.
// master drives requests and valid_wch, slave is the scheduler.
interface wch_scheduler_if #(
    parameter int N   = 8,
    parameter int W   = 24,
    parameter int IPW = 10
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    logic           upd_req;
    logic [N-1:0]   spike_vec;
    logic           learn_en;
    logic           lr_load;
    logic [W-1:0]   lr_plus_init;
    logic [W-1:0]   lr_minus_init;
    logic           valid_wch;

    logic           start_wch;
    logic           spike_hold;
    logic [IPW-1:0] ip_select;
    logic [NW-1:0]  nrn_sel;
    logic [W-1:0]   del_w_plus;
    logic [W-1:0]   del_w_minus;
    logic           busy;
    logic           done;
    logic           overrun;
    logic           timeout_err;

    modport master (
        output upd_req, spike_vec, learn_en, lr_load,
        output lr_plus_init, lr_minus_init, valid_wch,
        input  start_wch, spike_hold, ip_select, nrn_sel,
        input  del_w_plus, del_w_minus, busy, done,
        input  overrun, timeout_err
    );

    modport slave (
        input  upd_req, spike_vec, learn_en, lr_load,
        input  lr_plus_init, lr_minus_init, valid_wch,
        output start_wch, spike_hold, ip_select, nrn_sel,
        output del_w_plus, del_w_minus, busy, done,
        output overrun, timeout_err
    );

endinterface

// File: rtl/wch_scheduler_lr_decay.sv
// Learning-rate registers: direct load when idle, deferred
// load while a pass runs, floored decay at pass end.
module lr_decay
    import wch_scheduler_pkg::*;
#(
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_hold,
    input  logic         i_finish,
    input  logic [W-1:0] i_plus_init,
    input  logic [W-1:0] i_minus_init,
    output logic [W-1:0] o_plus,
    output logic [W-1:0] o_minus
);

    logic [W-1:0] r_plus;
    logic [W-1:0] r_minus;
    logic         r_pend;
    logic [W-1:0] r_pend_plus;
    logic [W-1:0] r_pend_minus;

    // Load beats pending load beats decay at pass end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plus       <= '0;
            r_minus      <= '0;
            r_pend       <= 1'b0;
            r_pend_plus  <= '0;
            r_pend_minus <= '0;
        end else if (i_finish) begin
            r_pend <= 1'b0;
            if (i_load) begin
                r_plus  <= i_plus_init;
                r_minus <= i_minus_init;
            end else if (r_pend) begin
                r_plus  <= r_pend_plus;
                r_minus <= r_pend_minus;
            end else begin
                r_plus  <= decay_floor(r_plus, DECAY_SHIFT);
                r_minus <= decay_floor(r_minus, DECAY_SHIFT);
            end
        end else if (i_hold) begin
            if (i_load) begin
                r_pend       <= 1'b1;
                r_pend_plus  <= i_plus_init;
                r_pend_minus <= i_minus_init;
            end
        end else if (i_load) begin
            r_plus  <= i_plus_init;
            r_minus <= i_minus_init;
        end
    end

    assign o_plus  = r_plus;
    assign o_minus = r_minus;

endmodule

// File: rtl/wch_scheduler.sv
// Weight-update pass scheduler: per neuron, one start
// pulse, an address sweep and a bounded wait for valid_wch.
module wch_scheduler
    import wch_scheduler_pkg::*;
#(
    parameter int M           = M_DEF,
    parameter int N           = N_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    wch_scheduler_if.slave  bus
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         r_state;
    state_t         w_state_nx;
    logic [IPW-1:0] r_ip;
    logic [NW-1:0]  r_nrn;
    logic [N-1:0]   r_cap;
    logic [TW-1:0]  r_tmo;
    logic           r_got;
    logic           r_ack;
    logic           r_ovr;
    logic           r_terr;

    logic           w_accept;
    logic           w_ack;
    logic           w_tmo_hit;
    logic           w_drop;
    logic           w_active;
    logic           w_finish;
    logic           w_seen;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next state plus per-cycle request/timeout decisions.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_ack      = 1'b0;
        w_tmo_hit  = 1'b0;
        w_seen     = bus.valid_wch | r_got;
        unique case (r_state)
            S_IDLE: begin
                if (bus.upd_req && !r_ack) begin
                    if (bus.learn_en) begin
                        w_accept   = 1'b1;
                        w_state_nx = S_START;
                    end else begin
                        w_ack = 1'b1;
                    end
                end
            end
            S_START: w_state_nx = S_SWEEP;
            S_SWEEP: begin
                if (r_ip == IPW'(M - 1))
                    w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (w_seen && r_tmo >= TW'(MIN_WAIT - 1)) begin
                    w_state_nx = S_NEXT;
                end else if (!w_seen &&
                             r_tmo == TW'(TIMEOUT - 1)) begin
                    w_tmo_hit  = 1'b1;
                    w_state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_nrn == NW'(N - 1)) w_state_nx = S_FINISH;
                else                     w_state_nx = S_START;
            end
            S_FINISH: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    assign w_active = (r_state == S_START) ||
                      (r_state == S_SWEEP) ||
                      (r_state == S_WAIT)  ||
                      (r_state == S_NEXT);
    assign w_finish = (r_state == S_FINISH);
    assign w_drop   = bus.upd_req &&
                      ((r_state != S_IDLE) || r_ack);

    // Captured spikes and neuron index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= '0;
            r_nrn <= '0;
        end else if (w_accept) begin
            r_cap <= bus.spike_vec;
            r_nrn <= '0;
        end else if (r_state == S_NEXT &&
                     w_state_nx == S_START) begin
            r_nrn <= r_nrn + NW'(1);
        end
    end

    // Address sweep: 0 with start, then 1..M-1, then back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ip <= '0;
        else if (r_state == S_START)
            r_ip <= IPW'(1);
        else if (r_state == S_SWEEP && w_state_nx == S_SWEEP)
            r_ip <= r_ip + IPW'(1);
        else
            r_ip <= '0;
    end

    // Wait-dwell counter; remembers an early valid_wch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_got <= 1'b0;
        end else if (r_state == S_WAIT &&
                     w_state_nx == S_WAIT) begin
            r_tmo <= r_tmo + TW'(1);
            r_got <= w_seen;
        end else begin
            r_tmo <= '0;
            r_got <= 1'b0;
        end
    end

    // Acknowledge-only done pulse and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_ovr  <= 1'b0;
            r_terr <= 1'b0;
        end else begin
            r_ack <= w_ack;
            if (w_drop)    r_ovr  <= 1'b1;
            if (w_tmo_hit) r_terr <= 1'b1;
        end
    end

    lr_decay #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_lr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (bus.lr_load),
        .i_hold       (w_active),
        .i_finish     (w_finish),
        .i_plus_init  (bus.lr_plus_init),
        .i_minus_init (bus.lr_minus_init),
        .o_plus       (bus.del_w_plus),
        .o_minus      (bus.del_w_minus)
    );

    assign bus.start_wch   = (r_state == S_START);
    assign bus.ip_select   = r_ip;
    assign bus.nrn_sel     = r_nrn;
    assign bus.spike_hold  = w_active & r_cap[r_nrn];
    assign bus.busy        = w_active;
    assign bus.done        = w_finish | r_ack;
    assign bus.overrun     = r_ovr;
    assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_wch_scheduler.sv
// Directed bench for wch_scheduler: vector table of passes
// plus timeout, overrun and mid-pass reset sequences.
module tb_wch_scheduler;
    import wch_scheduler_pkg::*;

    localparam int M = 784;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wch_scheduler_if #(.N(N), .W(W), .IPW(IPW)) bus();

    wch_scheduler #(
        .M(M), .N(N), .TIMEOUT(16), .DECAY_SHIFT(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int act,
                         input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    // Datapath model: valid_wch 5 cycles after the last address.
    bit dp_en = 1'b1;
    int cd = 0;
    initial begin
        bus.valid_wch = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.valid_wch = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && dp_en) bus.valid_wch = 1'b1;
            end
            if (bus.ip_select == 10'(M - 1)) cd = 5;
        end
    end

    // Monitor: counts pulses, logs spike_hold, checks sweep.
    int cyc = 0, starts = 0, dones = 0, sweeps = 0;
    int ip_bad = 0, sh_bad = 0, gap_bad = 0;
    int last_start = -100000;
    logic [9:0] prev_ip = '0;
    logic last_sh = 1'b0;
    logic sh_log [256];
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.start_wch) begin
                if (bus.ip_select != 10'd0) ip_bad++;
                if (cyc - last_start < M + 6) gap_bad++;
                last_start = cyc;
                sh_log[starts % 256] = bus.spike_hold;
                last_sh = bus.spike_hold;
                starts++;
            end else if (bus.ip_select != 10'd0 &&
                         bus.spike_hold != last_sh) begin
                sh_bad++;
            end
            if (bus.ip_select != 10'd0 &&
                bus.ip_select != 10'(prev_ip + 10'd1))
                ip_bad++;
            if (bus.ip_select == 10'(M - 1)) sweeps++;
            if (bus.done) dones++;
        end else begin
            last_start = -100000;
        end
        prev_ip = bus.ip_select;
    end

    task automatic load_lr(input logic [23:0] p,
                           input logic [23:0] m);
        @(posedge clk); #1;
        bus.lr_load       = 1'b1;
        bus.lr_plus_init  = p;
        bus.lr_minus_init = m;
        @(posedge clk); #1;
        bus.lr_load = 1'b0;
    endtask

    task automatic pulse_req(input logic [7:0] spk,
                             input logic lrn);
        @(posedge clk); #1;
        bus.upd_req   = 1'b1;
        bus.spike_vec = spk;
        bus.learn_en  = lrn;
        @(posedge clk); #1;
        bus.upd_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done && k < 9000);
        check(nm, int'(bus.done), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_nrn_ip(input int n, input int ip,
                               input string nm);
        int k;
        k = 0;
        while (!(int'(bus.nrn_sel) == n &&
                 (ip < 0 || int'(bus.ip_select) == ip)) &&
               k < 8000) begin
            @(posedge clk); #1;
            k++;
        end
        check(nm, int'(k < 8000), 1);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  spk;
        logic        learn;
        logic        load;
        logic [23:0] lp;
        logic [23:0] lm;
        int          exp_starts;
        logic [23:0] exp_p;
        logic [23:0] exp_m;
    } vec_t;

    vec_t vt [5];
    int s0, d0, w0, ib0, sb0, gb0;
    logic [7:0] pat;

    task automatic snap();
        s0 = starts; d0 = dones; w0 = sweeps;
        ib0 = ip_bad; sb0 = sh_bad; gb0 = gap_bad;
    endtask

    initial begin
        vt[0] = '{"p1",    8'h05, 1'b1, 1'b1, 24'd4096,
                  24'd4096, 8, 24'd4032, 24'd4032};
        vt[1] = '{"p2",    8'hA3, 1'b1, 1'b0, 24'd0,
                  24'd0,    8, 24'd3969, 24'd3969};
        vt[2] = '{"ack",   8'hFF, 1'b0, 1'b0, 24'd0,
                  24'd0,    0, 24'd3969, 24'd3969};
        vt[3] = '{"floor", 8'h80, 1'b1, 1'b1, 24'd1,
                  24'd1,    8, 24'd1,    24'd1};
        vt[4] = '{"mix",   8'h3C, 1'b1, 1'b1, 24'd1000,
                  24'd64,   8, 24'd985,  24'd63};

        rst = 1'b1;
        bus.upd_req = 1'b0;
        bus.spike_vec = '0;
        bus.learn_en = 1'b0;
        bus.lr_load = 1'b0;
        bus.lr_plus_init = '0;
        bus.lr_minus_init = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ctl", int'({bus.start_wch, bus.spike_hold,
              bus.busy, bus.done, bus.overrun,
              bus.timeout_err}), 0);
        check("rst_ip", int'(bus.ip_select), 0);
        check("rst_nrn", int'(bus.nrn_sel), 0);
        check("rst_plus", int'(bus.del_w_plus), 0);
        check("rst_minus", int'(bus.del_w_minus), 0);

        for (int i = 0; i < 5; i++) begin
            if (vt[i].load) load_lr(vt[i].lp, vt[i].lm);
            snap();
            pulse_req(vt[i].spk, vt[i].learn);
            wait_done({vt[i].name, "_done"});
            check({vt[i].name, "_starts"}, starts - s0,
                  vt[i].exp_starts);
            check({vt[i].name, "_sweeps"}, sweeps - w0,
                  vt[i].exp_starts);
            check({vt[i].name, "_dones"}, dones - d0, 1);
            check({vt[i].name, "_ipseq"}, ip_bad - ib0, 0);
            check({vt[i].name, "_shstable"}, sh_bad - sb0, 0);
            check({vt[i].name, "_gap"}, gap_bad - gb0, 0);
            check({vt[i].name, "_busy"}, int'(bus.busy), 0);
            check({vt[i].name, "_plus"},
                  int'(bus.del_w_plus), int'(vt[i].exp_p));
            check({vt[i].name, "_minus"},
                  int'(bus.del_w_minus), int'(vt[i].exp_m));
            if (vt[i].learn) begin
                for (int j = 0; j < 8; j++)
                    pat[j] = sh_log[(s0 + j) % 256];
                check({vt[i].name, "_spkhold"}, int'(pat),
                      int'(vt[i].spk));
            end
        end
        check("no_ovr", int'(bus.overrun), 0);
        check("no_terr", int'(bus.timeout_err), 0);

        // Timeout: datapath never answers.
        dp_en = 1'b0;
        snap();
        pulse_req(8'hFF, 1'b1);
        wait_done("tmo_done");
        dp_en = 1'b1;
        check("tmo_err", int'(bus.timeout_err), 1);
        check("tmo_starts", starts - s0, 8);
        check("tmo_dones", dones - d0, 1);
        check("tmo_plus", int'(bus.del_w_plus), 970);
        check("tmo_minus", int'(bus.del_w_minus), 63);

        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_terr", int'(bus.timeout_err), 0);

        // Overrun plus lr_load while busy (last one wins).
        load_lr(24'd4096, 24'd4096);
        snap();
        pulse_req(8'h0F, 1'b1);
        wait_nrn_ip(3, -1, "ovr_reach_n3");
        bus.upd_req = 1'b1;
        bus.lr_load = 1'b1;
        bus.lr_plus_init = 24'd500;
        bus.lr_minus_init = 24'd500;
        @(posedge clk); #1;
        bus.upd_req = 1'b0;
        bus.lr_plus_init = 24'd200;
        bus.lr_minus_init = 24'd300;
        @(posedge clk); #1;
        bus.lr_load = 1'b0;
        check("ovr_flag", int'(bus.overrun), 1);
        check("ovr_hold_plus", int'(bus.del_w_plus), 4096);
        wait_done("ovr_done");
        repeat (50) @(posedge clk);
        #1;
        check("ovr_dones", dones - d0, 1);
        check("ovr_starts", starts - s0, 8);
        check("ovr_plus", int'(bus.del_w_plus), 200);
        check("ovr_minus", int'(bus.del_w_minus), 300);
        check("ovr_sticky", int'(bus.overrun), 1);

        // Reset in the middle of neuron 2's sweep.
        pulse_req(8'hFF, 1'b1);
        wait_nrn_ip(2, 400, "mid_reach");
        d0 = dones;
        #2 rst = 1'b1;
        #1;
        check("mid_ctl", int'({bus.start_wch, bus.spike_hold,
              bus.busy, bus.done, bus.overrun,
              bus.timeout_err}), 0);
        check("mid_ip", int'(bus.ip_select), 0);
        check("mid_nrn", int'(bus.nrn_sel), 0);
        check("mid_plus", int'(bus.del_w_plus), 0);
        check("mid_minus", int'(bus.del_w_minus), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_nodone", dones - d0, 0);
        snap();
        pulse_req(8'h05, 1'b1);
        wait_done("post_done");
        check("post_starts", starts - s0, 8);
        check("post_dones", dones - d0, 1);
        for (int j = 0; j < 8; j++)
            pat[j] = sh_log[(s0 + j) % 256];
        check("post_spkhold", int'(pat), 5);
        check("post_plus", int'(bus.del_w_plus), 1);
        check("post_minus", int'(bus.del_w_minus), 1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/wch_scheduler.md
WCH_SCHEDULER -- requirements
Module: wch_scheduler

Interface
REQ-001 Parameter M, default 784, number of input synapses per output neuron (the sweep length).
REQ-002 Parameter N, default 8, number of output neurons / weight banks.
REQ-003 Parameter TIMEOUT, default 16, maximum number of cycles to wait for valid_wch after the last address.
REQ-004 Parameter DECAY_SHIFT, default 6, learning-rate decay shift per completed pass.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 upd_req  in  1  one-cycle pulse: image done, run a weight-update pass.
REQ-008 spike_vec  in  N  per-neuron spike flags; 1 = increase weights, 0 = decrease; sampled on an accepted upd_req.
REQ-009 learn_en  in  1  0 = requests are acknowledged without any update.
REQ-010 lr_load  in  1  pulse: load learning-rate registers from lr_plus_init and lr_minus_init.
REQ-011 lr_plus_init, lr_minus_init  in  24 each  initial del_w_plus and del_w_minus values (unsigned Q12).
REQ-012 valid_wch  in  1  completion pulse from the weight-change datapath.
REQ-013 start_wch  out  1  one-cycle start pulse to the datapath.
REQ-014 spike_hold  out  1  direction for the current neuron.
REQ-015 ip_select  out  10  synapse address sweep.
REQ-016 nrn_sel  out  3  weight bank currently being updated.
REQ-017 del_w_plus, del_w_minus  out  24 each  current learning rates.
REQ-018 busy  out  1  high from acceptance of a request until done.
REQ-019 done  out  1  one-cycle pulse when a pass ends.
REQ-020 overrun, timeout_err  out  1 each  sticky error flags.

Function
REQ-021 The FSM SHALL have the states IDLE, START, SWEEP, WAIT, NEXT and FINISH.
REQ-022 IDLE: upd_req with learn_en=1 SHALL capture spike_vec, set nrn_sel=0 and busy=1, and go to START; upd_req with learn_en=0 SHALL pulse done on the next cycle with no start_wch.
REQ-023 START: start_wch=1 for exactly one cycle, ip_select=0, spike_hold=captured spike_vec[nrn_sel]; next state SWEEP.
REQ-024 SWEEP: ip_select SHALL increment by 1 every cycle from 1 to M-1, so the address seen with start_wch is 0; after M-1 it SHALL return to 0 and the FSM SHALL go to WAIT.
REQ-025 WAIT: on valid_wch go to NEXT; if TIMEOUT cycles elapse without valid_wch, set timeout_err and go to NEXT.
REQ-026 NEXT: if nrn_sel==N-1 go to FINISH, else increment nrn_sel and go to START; start-to-start spacing is at least M+6 cycles.
REQ-027 FINISH: pulse done, clear busy, apply decay, return to IDLE.
REQ-028 Decay SHALL compute lr <= lr - (lr >> DECAY_SHIFT) on both rates, unsigned, floored at 1.
REQ-029 lr_load SHALL override decay in the same cycle.
REQ-030 lr_load while busy SHALL take effect only at FINISH, and the value loaded is the last one pulsed.
REQ-031 upd_req while busy (or in the done cycle) SHALL be dropped and SHALL set overrun.
REQ-032 spike_hold SHALL be stable from START through WAIT.
REQ-033 del_w_plus and del_w_minus SHALL change only in IDLE or FINISH.
REQ-034 A valid_wch outside WAIT SHALL be ignored.
REQ-035 overrun and timeout_err SHALL clear only on rst.

Reset
REQ-036 rst SHALL force state IDLE and clear start_wch, ip_select, nrn_sel, spike_hold, busy, done, overrun, timeout_err and the captured spike vector.
REQ-037 rst SHALL set del_w_plus and del_w_minus to 0.
REQ-038 rst mid-pass SHALL abort immediately with no done pulse.
REQ-039 After rst release, the first accepted upd_req SHALL behave as in REQ-022.

Structure
REQ-040 M, N, W=24, TIMEOUT, DECAY_SHIFT and the state encoding SHALL live in the shared snn package/header.
REQ-041 One sub-module, lr_decay, SHALL hold both rate registers, the load logic and the floored decay.
REQ-042 The FSM, sweep counter and timeout counter SHALL live in wch_scheduler.

Verification
REQ-043 Pass: upd_req with spike_vec=8'b0000_0101, learn_en=1, a datapath model returning valid_wch 5 cycles after ip_select=783 -> 8 start_wch pulses; spike_hold=1,0,1,0,0,0,0,0; ip_select 0..783 each; one done pulse; busy low afterwards.
REQ-044 Decay: lr_load with both rates 4096, then two passes -> rates 4032, then 3969.
REQ-045 Floor: lr_load with value 1 -> rates stay 1 after a pass.
REQ-046 Timeout: the model never returns valid_wch -> timeout_err=1, all 8 neurons still sequenced, done pulses.
REQ-047 Overrun: second upd_req during neuron 3 -> overrun=1 and only one done pulse.
REQ-048 Reset: rst asserted mid-SWEEP -> all outputs 0 in the same cycle, no done pulse; a new request then runs a full pass.
